qspi_mem_model: RTL

//  Parametrised, clocked SPI/QPI memory device model: successor to the fixed flash/PSRAM models on the SoC bench.

---
 rtl/qspi_mem_pkg.sv | 36 +++
 rtl/qspi_mem_if.sv | 33 +++
 rtl/qspi_edge_sync.sv | 50 +++++
 rtl/qspi_mem_model.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_mem_pkg
//  Purpose  : Opcodes, FSM state encoding and counter-width helper shared by
//             the QSPI memory model.
//  Revision : 1.0 - initial release
// ============================================================================
package qspi_mem_pkg;

    localparam logic [7:0] c_OP_READ       = 8'h03;
    localparam logic [7:0] c_OP_FAST_READ  = 8'h0B;
    localparam logic [7:0] c_OP_QUAD_READ  = 8'hEB;
    localparam logic [7:0] c_OP_WRITE      = 8'h02;
    localparam logic [7:0] c_OP_QUAD_WRITE = 8'h38;
    localparam logic [7:0] c_OP_ENTER_QPI  = 8'h35;
    localparam logic [7:0] c_OP_EXIT_QPI   = 8'hF5;
    localparam logic [7:0] c_OP_RST_EN     = 8'h66;
    localparam logic [7:0] c_OP_RST        = 8'h99;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RD     = 3'd4,
        ST_WR     = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // Width needed for a counter that must reach max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_mem_if
//  Purpose  : Serial pins plus backdoor preload port of the memory model.
//             master = bus host / bench, slave = memory device.
//  Revision : 1.0 - initial release
// ============================================================================
interface qspi_mem_if
    import qspi_mem_pkg::*;
#(
    parameter int ADDR_BITS = 24
);
    logic                 ce_n;
    logic                 sck;
    logic [3:0]           dio_in;
    logic [3:0]           dio_out;
    logic [3:0]           dio_oe;
    logic                 qpi_mode;
    logic                 bd_we;
    logic [ADDR_BITS-1:0] bd_addr;
    logic [7:0]           bd_wdata;

    modport master (
        output ce_n, sck, dio_in, bd_we, bd_addr, bd_wdata,
        input  dio_out, dio_oe, qpi_mode
    );

    modport slave (
        input  ce_n, sck, dio_in, bd_we, bd_addr, bd_wdata,
        output dio_out, dio_oe, qpi_mode
    );
endinterface
`default_nettype wire

// File: rtl/qspi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_edge_sync
//  Purpose  : Synchronises CE#, SCK and IO0..3 into the system clock and
//             detects SCK rising/falling edges on the synchronised value.
//  Revision : 1.0 - initial release
// ============================================================================
module qspi_edge_sync
    import qspi_mem_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_ce_n,
    input  wire logic       i_sck,
    input  wire logic [3:0] i_dio,
    output logic            o_ce_n,
    output logic            o_sck_rise,
    output logic            o_sck_fall,
    output logic [3:0]      o_dio
);
    localparam int         c_W        = 6 * SYNC_STAGES;
    // {ce_n, sck, dio}: deselected, clock low
    localparam logic [5:0] c_IDLE_LVL = 6'b10_0000;

    logic [c_W-1:0] r_sync;
    logic           r_sck_d;
    logic [5:0]     w_last;

    assign w_last = r_sync[c_W-1 -: 6];

    // Shift chain: newest sample enters at the bottom, oldest leaves at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= {SYNC_STAGES{c_IDLE_LVL}};
            r_sck_d <= 1'b0;
        end else begin
            r_sync  <= c_W'({r_sync, i_ce_n, i_sck, i_dio});
            r_sck_d <= w_last[4];
        end
    end

    assign o_ce_n     = w_last[5];
    assign o_sck_rise =  w_last[4] & ~r_sck_d;
    assign o_sck_fall = ~w_last[4] &  r_sck_d;
    assign o_dio      = w_last[3:0];

endmodule
`default_nettype wire

// File: rtl/qspi_mem_model.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_mem_model
//  Purpose  : Clocked SPI/QSPI/QPI memory device model with backdoor preload.
//             Serves as boot flash (WRITABLE=0) or PSRAM (WRITABLE=1).
//  Revision : 1.0 - initial release
// ============================================================================
module qspi_mem_model
    import qspi_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 65536,
    parameter int ADDR_BITS   = 24,
    parameter int FAST_WAIT   = 8,
    parameter int QUAD_WAIT   = 6,
    parameter int SYNC_STAGES = 2,
    parameter int WRITABLE    = 1
) (
    input wire logic   clk,
    input wire logic   rst,
    qspi_mem_if.slave  bus
);
    localparam int c_AW       = $clog2(DEPTH_BYTES);
    localparam int c_ADDR_NIB = (ADDR_BITS + 3) / 4;
    localparam int c_SH_A     = (ADDR_BITS > c_AW) ? ADDR_BITS : c_AW;
    localparam int c_SH_W     = (c_SH_A > 8) ? c_SH_A : 8;
    localparam int c_WT_MAX   = (FAST_WAIT > QUAD_WAIT) ? FAST_WAIT : QUAD_WAIT;
    localparam int c_CNT_MAX  = (ADDR_BITS > c_WT_MAX) ? ADDR_BITS : c_WT_MAX;
    localparam int c_CNT_W    = cnt_width((c_CNT_MAX > 8) ? c_CNT_MAX : 8);

    logic             w_ce_n, w_rise, w_fall;
    logic [3:0]       w_dio;

    state_t           r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [c_CNT_W-1:0] r_wait, w_wait_nxt;
    logic [c_SH_W-1:0]  r_sh, w_sh_nxt, w_shifted;
    logic [c_AW-1:0]    r_addr, w_addr_nxt;
    logic             r_quad, w_quad_nxt;
    logic             r_read, w_read_nxt;
    logic             r_qpi, w_qpi_nxt;
    logic             r_last66, w_last66_nxt;
    logic [3:0]       r_out, w_out_nxt;
    logic [3:0]       r_oe, w_oe_nxt;
    logic             w_commit;
    logic [7:0]       w_op, w_rd_byte;
    logic [7:0]       r_mem [DEPTH_BYTES];

    qspi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_ce_n     (bus.ce_n),
        .i_sck      (bus.sck),
        .i_dio      (bus.dio_in),
        .o_ce_n     (w_ce_n),
        .o_sck_rise (w_rise),
        .o_sck_fall (w_fall),
        .o_dio      (w_dio)
    );

    assign w_rd_byte = r_mem[r_addr];
    assign w_op      = w_shifted[7:0];

    // Next-state and datapath decode for the serial protocol.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wait_nxt   = r_wait;
        w_sh_nxt     = r_sh;
        w_addr_nxt   = r_addr;
        w_quad_nxt   = r_quad;
        w_read_nxt   = r_read;
        w_qpi_nxt    = r_qpi;
        w_last66_nxt = r_last66;
        w_out_nxt    = r_out;
        w_oe_nxt     = r_oe;
        w_commit     = 1'b0;
        w_shifted    = r_quad ? {r_sh[c_SH_W-5:0], w_dio} : {r_sh[c_SH_W-2:0], w_dio[0]};

        unique case (r_state)
            ST_IDLE: begin
                w_out_nxt = 4'b0000;
                w_oe_nxt  = 4'b0000;
                if (!w_ce_n) begin
                    w_state_nxt = ST_CMD;
                    w_cnt_nxt   = '0;
                    w_sh_nxt    = '0;
                    w_quad_nxt  = r_qpi;
                end
            end
            ST_CMD: begin
                if (w_rise) begin
                    w_sh_nxt  = w_shifted;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == (r_quad ? c_CNT_W'(1) : c_CNT_W'(7))) begin
                        // Opcode complete: any command other than 0x66 disarms reset
                        w_cnt_nxt    = '0;
                        w_sh_nxt     = '0;
                        w_last66_nxt = 1'b0;
                        w_state_nxt  = ST_IGNORE;
                        case (w_op)
                            c_OP_READ: if (!r_qpi) begin
                                w_state_nxt = ST_ADDR;
                                w_read_nxt  = 1'b1;
                                w_wait_nxt  = '0;
                                w_quad_nxt  = 1'b0;
                            end
                            c_OP_FAST_READ: begin
                                w_state_nxt = ST_ADDR;
                                w_read_nxt  = 1'b1;
                                w_wait_nxt  = r_qpi ? c_CNT_W'(QUAD_WAIT) : c_CNT_W'(FAST_WAIT);
                                w_quad_nxt  = r_qpi;
                            end
                            c_OP_QUAD_READ: begin
                                w_state_nxt = ST_ADDR;
                                w_read_nxt  = 1'b1;
                                w_wait_nxt  = c_CNT_W'(QUAD_WAIT);
                                w_quad_nxt  = 1'b1;
                            end
                            c_OP_WRITE: if (WRITABLE != 0) begin
                                w_state_nxt = ST_ADDR;
                                w_read_nxt  = 1'b0;
                                w_quad_nxt  = r_qpi;
                            end
                            c_OP_QUAD_WRITE: if (WRITABLE != 0) begin
                                w_state_nxt = ST_ADDR;
                                w_read_nxt  = 1'b0;
                                w_quad_nxt  = 1'b1;
                            end
                            c_OP_ENTER_QPI: w_qpi_nxt    = 1'b1;
                            c_OP_EXIT_QPI:  w_qpi_nxt    = 1'b0;
                            c_OP_RST_EN:    w_last66_nxt = 1'b1;
                            c_OP_RST:       if (r_last66) w_qpi_nxt = 1'b0;
                            default: ;
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                if (w_rise) begin
                    w_sh_nxt  = w_shifted;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == (r_quad ? c_CNT_W'(c_ADDR_NIB - 1) : c_CNT_W'(ADDR_BITS - 1))) begin
                        // Upper address bits beyond the storage size are dropped
                        w_addr_nxt = w_shifted[c_AW-1:0];
                        w_cnt_nxt  = '0;
                        w_sh_nxt   = '0;
                        if (!r_read)           w_state_nxt = ST_WR;
                        else if (r_wait == '0) w_state_nxt = ST_RD;
                        else                   w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_rise) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == r_wait - 1'b1) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (w_fall) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_quad) begin
                        w_oe_nxt  = 4'b1111;
                        w_out_nxt = r_cnt[0] ? w_rd_byte[3:0] : w_rd_byte[7:4];
                    end else begin
                        w_oe_nxt  = 4'b0010;
                        w_out_nxt = {2'b00, w_rd_byte[3'd7 - r_cnt[2:0]], 1'b0};
                    end
                    if (r_cnt == (r_quad ? c_CNT_W'(1) : c_CNT_W'(7))) begin
                        w_cnt_nxt  = '0;
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (w_rise) begin
                    w_sh_nxt  = w_shifted;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == (r_quad ? c_CNT_W'(1) : c_CNT_W'(7))) begin
                        w_commit   = 1'b1;
                        w_cnt_nxt  = '0;
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
            ST_IGNORE: ;
            default: w_state_nxt = ST_IDLE;
        endcase

        // Deselect aborts everything; an unfinished opcode breaks a 0x66/0x99 pair
        if (w_ce_n) begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = 4'b0000;
            w_oe_nxt    = 4'b0000;
            w_commit    = 1'b0;
            if (r_state == ST_CMD) w_last66_nxt = 1'b0;
        end
    end

    // State and control register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wait   <= '0;
            r_sh     <= '0;
            r_addr   <= '0;
            r_quad   <= 1'b0;
            r_read   <= 1'b0;
            r_qpi    <= 1'b0;
            r_last66 <= 1'b0;
            r_out    <= 4'b0000;
            r_oe     <= 4'b0000;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wait   <= w_wait_nxt;
            r_sh     <= w_sh_nxt;
            r_addr   <= w_addr_nxt;
            r_quad   <= w_quad_nxt;
            r_read   <= w_read_nxt;
            r_qpi    <= w_qpi_nxt;
            r_last66 <= w_last66_nxt;
            r_out    <= w_out_nxt;
            r_oe     <= w_oe_nxt;
        end
    end

    // Storage survives reset; a serial commit overrides a same-address backdoor write.
    always_ff @(posedge clk) begin
        if (bus.bd_we) r_mem[bus.bd_addr[c_AW-1:0]] <= bus.bd_wdata;
        if (w_commit)  r_mem[r_addr] <= w_shifted[7:0];
    end

    assign bus.dio_out  = r_out;
    assign bus.dio_oe   = r_oe;
    assign bus.qpi_mode = r_qpi;

endmodule
`default_nettype wire
